// File: rtl/elastic_pipeline_register_if.sv
// Valid/ready stream bundle for elastic_pipeline_register.
// Upstream side: In_Data, In_Valid, Out_Ready. Downstream side: Out_Data, Out_Valid, In_Ready.
// In_Flush travels with the bundle because it qualifies every transfer on it.
// The slave modport is the pipeline's view; the master modport is the surrounding logic's view.
interface elastic_pipeline_register_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] In_Data;
    logic             In_Valid;
    logic             Out_Ready;
    logic [WIDTH-1:0] Out_Data;
    logic             Out_Valid;
    logic             In_Ready;
    logic             In_Flush;

    modport master (
        output In_Data,
        output In_Valid,
        output In_Ready,
        output In_Flush,
        input  Out_Ready,
        input  Out_Data,
        input  Out_Valid
    );

    modport slave (
        input  In_Data,
        input  In_Valid,
        input  In_Ready,
        input  In_Flush,
        output Out_Ready,
        output Out_Data,
        output Out_Valid
    );
endinterface

// File: rtl/elastic_pipeline_register.sv
// Chain of STAGES elastic stages.
// Each stage has a main register and a skid register, so upstream ready is a pure register
// decode and never depends combinationally on the downstream ready.
// Optional occupancy counter: define PIPEREG_OCCUPANCY_EN to add the Out_Count port.
module elastic_pipeline_register #(
    parameter int unsigned      WIDTH   = 32,
    parameter int unsigned      STAGES  = 1,
    parameter logic [WIDTH-1:0] PRELOAD = '0
) (
    input  logic                              In_Clock,
    input  logic                              In_Reset_n,
    elastic_pipeline_register_if.slave        bus
`ifdef PIPEREG_OCCUPANCY_EN
    ,
    output logic [$clog2(2*STAGES+1)-1:0]     Out_Count
`endif
);

    typedef enum logic [1:0] {StEmpty, StBusy, StFull} state_e;

    state_e           state_q [STAGES];
    state_e           state_d [STAGES];
    logic [WIDTH-1:0] main_q  [STAGES];
    logic [WIDTH-1:0] main_d  [STAGES];
    logic [WIDTH-1:0] skid_q  [STAGES];
    logic [WIDTH-1:0] skid_d  [STAGES];
    logic [WIDTH-1:0] in_data [STAGES];

    logic [STAGES-1:0] st_valid;
    logic [STAGES-1:0] st_ready;
    logic [STAGES-1:0] in_valid;
    logic [STAGES-1:0] dn_ready;
    logic [STAGES-1:0] in_fire;
    logic [STAGES-1:0] out_fire;

    // Stitch stages into a chain and derive per-stage handshakes.
    always_comb begin
        in_valid = '0;
        dn_ready = '0;
        for (int k = 0; k < STAGES; k++) begin
            st_valid[k] = (state_q[k] != StEmpty);
            st_ready[k] = (state_q[k] != StFull);
        end
        in_valid[0] = bus.In_Valid;
        in_data[0]  = bus.In_Data;
        for (int k = 1; k < STAGES; k++) begin
            in_valid[k] = st_valid[k-1];
            in_data[k]  = main_q[k-1];
        end
        for (int k = 0; k < STAGES - 1; k++) begin
            dn_ready[k] = st_ready[k+1];
        end
        dn_ready[STAGES-1] = bus.In_Ready;
        in_fire  = in_valid & st_ready;
        out_fire = st_valid & dn_ready;
    end

    // Per-stage next state; flush overrides any concurrent transfer and drops its word.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            state_d[k] = state_q[k];
            main_d[k]  = main_q[k];
            skid_d[k]  = skid_q[k];
            unique case (state_q[k])
                StEmpty: begin
                    if (in_fire[k]) begin
                        main_d[k]  = in_data[k];
                        state_d[k] = StBusy;
                    end
                end
                StBusy: begin
                    if (in_fire[k] && out_fire[k]) begin
                        main_d[k] = in_data[k];
                    end else if (in_fire[k]) begin
                        skid_d[k]  = in_data[k];
                        state_d[k] = StFull;
                    end else if (out_fire[k]) begin
                        state_d[k] = StEmpty;
                    end
                end
                StFull: begin
                    if (out_fire[k]) begin
                        main_d[k]  = skid_q[k];
                        state_d[k] = StBusy;
                    end
                end
                default: state_d[k] = StEmpty;
            endcase
            if (bus.In_Flush) begin
                state_d[k] = StEmpty;
                main_d[k]  = PRELOAD;
                skid_d[k]  = PRELOAD;
            end
        end
    end

    // Stage state and data registers.
    always_ff @(posedge In_Clock or negedge In_Reset_n) begin
        if (!In_Reset_n) begin
            for (int k = 0; k < STAGES; k++) begin
                state_q[k] <= StEmpty;
                main_q[k]  <= PRELOAD;
                skid_q[k]  <= PRELOAD;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                state_q[k] <= state_d[k];
                main_q[k]  <= main_d[k];
                skid_q[k]  <= skid_d[k];
            end
        end
    end

    assign bus.Out_Ready = st_ready[0];
    assign bus.Out_Valid = st_valid[STAGES-1];
    assign bus.Out_Data  = main_q[STAGES-1];

`ifdef PIPEREG_OCCUPANCY_EN
    localparam int unsigned CountW = $clog2(2*STAGES+1);

    logic [CountW-1:0] count_q;
    logic [CountW-1:0] count_d;

    // Words held across the whole chain: +1 on entry, -1 on exit.
    always_comb begin
        count_d = count_q;
        if (bus.In_Flush) begin
            count_d = '0;
        end else if (in_fire[0] && !out_fire[STAGES-1]) begin
            count_d = count_q + CountW'(1);
        end else if (!in_fire[0] && out_fire[STAGES-1]) begin
            count_d = count_q - CountW'(1);
        end
    end

    // Occupancy register.
    always_ff @(posedge In_Clock or negedge In_Reset_n) begin
        if (!In_Reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign Out_Count = count_q;
`endif

endmodule

// File: tb/tb_elastic_pipeline_register.sv
// Bench for elastic_pipeline_register: two instances (STAGES=2 and STAGES=1, WIDTH=8).
// Each stage is modelled as a two-entry queue; a negedge process compares every output.
module tb_elastic_pipeline_register;

    localparam logic [7:0] PreA = 8'hA5;
    localparam logic [7:0] PreB = 8'h3C;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    elastic_pipeline_register_if #(.WIDTH(8)) bus_a ();
    elastic_pipeline_register_if #(.WIDTH(8)) bus_b ();

`ifdef PIPEREG_OCCUPANCY_EN
    logic [2:0] cnt_a;
    logic [1:0] cnt_b;
`endif

    elastic_pipeline_register #(.WIDTH(8), .STAGES(2), .PRELOAD(PreA)) u_dut_a (
        .In_Clock   (clk),
        .In_Reset_n (rst_n),
        .bus        (bus_a)
`ifdef PIPEREG_OCCUPANCY_EN
        ,
        .Out_Count  (cnt_a)
`endif
    );

    elastic_pipeline_register #(.WIDTH(8), .STAGES(1), .PRELOAD(PreB)) u_dut_b (
        .In_Clock   (clk),
        .In_Reset_n (rst_n),
        .bus        (bus_b)
`ifdef PIPEREG_OCCUPANCY_EN
        ,
        .Out_Count  (cnt_b)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: per instance, per stage, a queue of at most two words plus the last head value.
    int         m_cnt  [2][2];
    logic [7:0] m_buf  [2][2][2];
    logic [7:0] m_last [2][2];
    int         m_occ  [2];

    function automatic int ns_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic logic [7:0] pre_of(input int i);
        return (i == 0) ? PreA : PreB;
    endfunction

    task automatic m_reset(input int i);
        for (int k = 0; k < 2; k++) begin
            m_cnt[i][k]     = 0;
            m_last[i][k]    = pre_of(i);
            m_buf[i][k][0]  = pre_of(i);
            m_buf[i][k][1]  = pre_of(i);
        end
        m_occ[i] = 0;
    endtask

    function automatic logic [7:0] m_front(input int i, input int k);
        return (m_cnt[i][k] > 0) ? m_buf[i][k][0] : m_last[i][k];
    endfunction

    function automatic logic m_ready(input int i);
        return m_cnt[i][0] < 2;
    endfunction

    function automatic logic m_valid(input int i);
        return m_cnt[i][ns_of(i)-1] > 0;
    endfunction

    function automatic logic [7:0] m_data(input int i);
        return m_front(i, ns_of(i) - 1);
    endfunction

    task automatic m_step(input int i, input logic iv, input logic [7:0] id, input logic ir,
                          input logic fl);
        int         ns;
        logic       vin  [2];
        logic [7:0] din  [2];
        logic       rdn  [2];
        logic       inf  [2];
        logic       outf [2];
        ns = ns_of(i);
        if (fl) begin
            m_reset(i);
        end else begin
            for (int k = 0; k < ns; k++) begin
                if (k == 0) begin
                    vin[k] = iv;
                    din[k] = id;
                end else begin
                    vin[k] = m_cnt[i][k-1] > 0;
                    din[k] = m_front(i, k - 1);
                end
                if (k == ns - 1) rdn[k] = ir;
                else             rdn[k] = m_cnt[i][k+1] < 2;
                inf[k]  = vin[k] && (m_cnt[i][k] < 2);
                outf[k] = (m_cnt[i][k] > 0) && rdn[k];
            end
            for (int k = 0; k < ns; k++) begin
                if (outf[k]) begin
                    m_buf[i][k][0] = m_buf[i][k][1];
                    m_cnt[i][k]--;
                end
                if (inf[k]) begin
                    m_buf[i][k][m_cnt[i][k]] = din[k];
                    m_cnt[i][k]++;
                end
                if (m_cnt[i][k] > 0) m_last[i][k] = m_buf[i][k][0];
            end
            if (inf[0])     m_occ[i]++;
            if (outf[ns-1]) m_occ[i]--;
        end
    endtask

    // Advance the model on the same events that move the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reset(0);
            m_reset(1);
        end else begin
            m_step(0, bus_a.In_Valid, bus_a.In_Data, bus_a.In_Ready, bus_a.In_Flush);
            m_step(1, bus_b.In_Valid, bus_b.In_Data, bus_b.In_Ready, bus_b.In_Flush);
        end
    end

    // Compare every output of both instances against the model each cycle.
    always @(negedge clk) begin
        chk("a_valid", bus_a.Out_Valid, m_valid(0));
        chk("a_ready", bus_a.Out_Ready, m_ready(0));
        chk("a_data",  bus_a.Out_Data,  m_data(0));
        chk("b_valid", bus_b.Out_Valid, m_valid(1));
        chk("b_ready", bus_b.Out_Ready, m_ready(1));
        chk("b_data",  bus_b.Out_Data,  m_data(1));
`ifdef PIPEREG_OCCUPANCY_EN
        chk("a_count", cnt_a, m_occ[0]);
        chk("b_count", cnt_b, m_occ[1]);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] outs [16];
    int         outk [16];
    int         first_k, n_out, rdy_low, acc, stable_bad, ready_k, leak;
    logic       got_full;

    initial begin
        m_reset(0);
        m_reset(1);
        bus_a.In_Valid = 1'b0; bus_a.In_Data = '0; bus_a.In_Ready = 1'b0; bus_a.In_Flush = 1'b0;
        bus_b.In_Valid = 1'b0; bus_b.In_Data = '0; bus_b.In_Ready = 1'b0; bus_b.In_Flush = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid", bus_a.Out_Valid, 1'b0);
        chk("rst_data",  bus_a.Out_Data,  8'hA5);
        chk("rst_ready", bus_a.Out_Ready, 1'b1);
`ifdef PIPEREG_OCCUPANCY_EN
        chk("rst_count", cnt_a, 0);
`endif
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Streaming: words 1..10 back to back, no backpressure.
        bus_a.In_Ready = 1'b1;
        first_k = -1; n_out = 0; rdy_low = 0;
        for (int k = 0; k < 14; k++) begin
            bus_a.In_Valid = (k < 10);
            bus_a.In_Data  = 8'(k + 1);
            @(negedge clk);
            if (!bus_a.Out_Ready) rdy_low++;
            if (bus_a.Out_Valid && n_out < 16) begin
                if (first_k < 0) first_k = k;
                outs[n_out] = bus_a.Out_Data;
                outk[n_out] = k;
                n_out++;
            end
            tick();
        end
        bus_a.In_Valid = 1'b0;
        chk("stream_latency", first_k, 2);
        chk("stream_count", n_out, 10);
        chk("stream_ready_low", rdy_low, 0);
        for (int j = 0; j < 10; j++) begin
            if (j < n_out) begin
                chk("stream_data", outs[j], j + 1);
                chk("stream_cycle", outk[j], first_k + j);
            end
        end

        // Backpressure: fill the chain, then drain it.
        bus_a.In_Ready = 1'b0;
        acc = 0; stable_bad = 0; got_full = 1'b0;
        for (int k = 0; k < 20 && !got_full; k++) begin
            bus_a.In_Valid = 1'b1;
            bus_a.In_Data  = 8'(8'h10 + acc);
            @(negedge clk);
            if (bus_a.Out_Valid && bus_a.Out_Data !== 8'h10) stable_bad++;
            if (!bus_a.Out_Ready) begin
                got_full = 1'b1;
`ifdef PIPEREG_OCCUPANCY_EN
                chk("bp_count", cnt_a, 4);
`endif
            end else begin
                acc++;
            end
            tick();
        end
        chk("bp_full_seen", got_full, 1'b1);
        chk("bp_accepted", acc, 4);
        chk("bp_hold", stable_bad, 0);
        bus_a.In_Valid = 1'b0;
        bus_a.In_Ready = 1'b1;
        n_out = 0; first_k = -1; ready_k = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus_a.Out_Valid && n_out < 16) begin
                if (first_k < 0) first_k = k;
                outs[n_out] = bus_a.Out_Data;
                n_out++;
            end
            if (ready_k < 0 && bus_a.Out_Ready) ready_k = k;
            tick();
        end
        chk("bp_drain_count", n_out, 4);
        for (int j = 0; j < 4; j++) begin
            if (j < n_out) chk("bp_drain_data", outs[j], 8'h10 + j);
        end
        // First out-fire is on the edge closing cycle first_k; Out_Ready is back one edge later.
        chk("bp_ready_return", ready_k - first_k, 2);

        // Simultaneous in/out on a full single-stage chain.
        bus_b.In_Valid = 1'b1; bus_b.In_Data = 8'h21;
        tick();
        bus_b.In_Data = 8'h22;
        tick();
        bus_b.In_Data = 8'h23; bus_b.In_Ready = 1'b1;
        @(negedge clk);
        chk("sim_ready_full", bus_b.Out_Ready, 1'b0);
        chk("sim_data_first", bus_b.Out_Data, 8'h21);
        tick();
        @(negedge clk);
        chk("sim_data_skid", bus_b.Out_Data, 8'h22);
        chk("sim_ready_back", bus_b.Out_Ready, 1'b1);
        tick();
        bus_b.In_Valid = 1'b0;
        @(negedge clk);
        chk("sim_data_new", bus_b.Out_Data, 8'h23);
        chk("sim_valid_new", bus_b.Out_Valid, 1'b1);
        tick();
        tick();

        // Flush with three words held and a concurrent offered word.
        bus_a.In_Ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus_a.In_Valid = 1'b1;
            bus_a.In_Data  = 8'(8'h31 + k);
            tick();
        end
        bus_a.In_Data  = 8'h77;
        bus_a.In_Flush = 1'b1;
        @(negedge clk);
        chk("flush_cycle_ready", bus_a.Out_Ready, 1'b1);
        tick();
        bus_a.In_Flush = 1'b0;
        bus_a.In_Valid = 1'b0;
        bus_a.In_Ready = 1'b1;
        @(negedge clk);
        chk("flush_valid", bus_a.Out_Valid, 1'b0);
        chk("flush_data", bus_a.Out_Data, 8'hA5);
        chk("flush_ready", bus_a.Out_Ready, 1'b1);
`ifdef PIPEREG_OCCUPANCY_EN
        chk("flush_count", cnt_a, 0);
`endif
        leak = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            @(negedge clk);
            if (bus_a.Out_Valid) leak++;
        end
        chk("flush_no_leak", leak, 0);
        tick();

        // Asynchronous reset while both instances are full.
        bus_a.In_Ready = 1'b0; bus_b.In_Ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus_a.In_Valid = 1'b1; bus_a.In_Data = 8'(8'h41 + k);
            bus_b.In_Valid = 1'b1; bus_b.In_Data = 8'(8'h61 + k);
            tick();
        end
        bus_a.In_Valid = 1'b0; bus_b.In_Valid = 1'b0;
        @(negedge clk);
        chk("ar_pre_full", bus_a.Out_Ready, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", bus_a.Out_Valid, 1'b0);
        chk("ar_data", bus_a.Out_Data, 8'hA5);
        chk("ar_ready", bus_a.Out_Ready, 1'b1);
        chk("ar_b_data", bus_b.Out_Data, 8'h3C);
        chk("ar_b_ready", bus_b.Out_Ready, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
        bus_a.In_Ready = 1'b1;
        first_k = -1; n_out = 0;
        for (int k = 0; k < 8; k++) begin
            bus_a.In_Valid = (k < 3);
            bus_a.In_Data  = 8'(8'h51 + k);
            @(negedge clk);
            if (bus_a.Out_Valid && n_out < 16) begin
                if (first_k < 0) first_k = k;
                outs[n_out] = bus_a.Out_Data;
                n_out++;
            end
            tick();
        end
        bus_a.In_Valid = 1'b0;
        chk("ar_resume_latency", first_k, 2);
        chk("ar_resume_count", n_out, 3);
        if (n_out > 0) chk("ar_resume_first", outs[0], 8'h51);

        // Random traffic on both instances, checked cycle by cycle against the model.
        for (int k = 0; k < 600; k++) begin
            bus_a.In_Valid = ($urandom_range(0, 3) != 0);
            bus_a.In_Data  = 8'($urandom);
            bus_a.In_Ready = ($urandom_range(0, 2) != 0) || (k > 300 && k < 400);
            bus_a.In_Flush = ($urandom_range(0, 63) == 0);
            bus_b.In_Valid = ($urandom_range(0, 1) != 0);
            bus_b.In_Data  = 8'($urandom);
            bus_b.In_Ready = ($urandom_range(0, 3) == 0) || (k > 450);
            bus_b.In_Flush = ($urandom_range(0, 63) == 0);
            tick();
        end
        bus_a.In_Valid = 1'b0; bus_a.In_Flush = 1'b0; bus_a.In_Ready = 1'b1;
        bus_b.In_Valid = 1'b0; bus_b.In_Flush = 1'b0; bus_b.In_Ready = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        chk("end_a_empty", bus_a.Out_Valid, 1'b0);
        chk("end_b_empty", bus_b.Out_Valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
